rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single byte-wide puzzle-input ROM port (addr/data/valid) between two independent scanning engines, e.g. a part-1 and a part-2 range parser inside a dayNN_core.
- Round-robin grant of one read per cycle.
- Tracks in-flight reads in a tag pipeline and returns each byte only to the requester that issued it.
- Sits between the engines and the rom instance; the ROM's read latency is fixed by parameter.

Parameters:
N_ADDR_BITS, 16, ROM address MSB index; address buses are N_ADDR_BITS+1 bits wide.
ROM_LATENCY, 1, cycles from rom_addr being sampled to rom_data/rom_valid being usable (1..4).
CNT_WIDTH, 32, width of the contention counter.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req0  in  1  requester 0 read request
addr0  in  N_ADDR_BITS+1  requester 0 byte address
gnt0  out  1  requester 0 request accepted this cycle (combinational)
rsp0_valid  out  1  response byte for requester 0 present
rsp0_data  out  8  response byte
rsp0_eof  out  1  address was past end of file (rom_valid was 0)
req1, addr1, gnt1, rsp1_valid, rsp1_data, rsp1_eof  same as above for requester 1
rom_addr  out  N_ADDR_BITS+1  address to ROM
rom_data  in  8  ROM byte
rom_valid  in  1  ROM byte inside file
busy  out  1  at least one read in flight
contention_count  out  CNT_WIDTH  cycles in which req0 and req1 were both high

Behaviour:
- Arbitration is combinational in the cycle of the request:
  - only reqN high -> gntN=1;
  - both high -> grant goes to requester `prio`;
  - neither high -> no grant.
- gnt0 and gnt1 are never both 1.
- `prio` register, reset 0. On any grant to requester W, `prio` <= ~W next cycle.
- Two consecutive contended cycles therefore grant 0 then 1.
- rom_addr:
  - on a grant, rom_addr = addr of the winner, same cycle;
  - with no grant, rom_addr = last_addr register (last granted address, reset 0).
- A requester holds reqN/addrN stable until gntN. The arbiter does not check this.
- Tag pipeline: ROM_LATENCY stages of {valid, id}.
  - Stage 0 is loaded with {grant_any, winner} at the clock edge.
  - The final stage drives the response outputs.
- Response timing:
  - A read granted in cycle T gives rspW_valid=1 in cycle T+ROM_LATENCY.
  - In that cycle rspW_data = rom_data and rspW_eof = ~rom_valid.
  - The other requester's rsp_valid is 0 in that cycle.
- Throughput is one read per cycle; back-to-back grants produce back-to-back responses in grant order.
- rspN_data/rspN_eof are don't-care when rspN_valid=0, but are driven 0 to keep waveforms clean.
- busy = OR of all tag-pipeline valid bits.
- contention_count increments when req0 & req1; it saturates at all-ones.
- Reset values: prio=0, last_addr=0, all tag valids=0, contention_count=0, busy=0.
  - All rsp* outputs are 0.
  - gnt* and rom_addr are combinational and follow the reset state; gnt is forced 0 while rst=1.
- Reset mid-operation: in-flight reads are discarded. No rsp_valid fires in any cycle after rst is sampled high. Requesters must reissue.
- Boundary conditions:
  - Address past end of file: returns rsp_eof=1 with data driven as supplied by the ROM. It is not an error.
  - Address wrap at all-ones is the requester's concern; the arbiter passes addresses unmodified.
  - A request in the same cycle a response returns is legal and independent.

Decomposition:
- Shared package (aoc_pkg): ROM data width 8 and the requester-ID type (1 bit).
- One natural sub-module, rom_tag_pipe: a parameterised ROM_LATENCY-deep valid/id shift register with synchronous clear.
- Arbiter logic and counters stay in rom_port_arbiter.

Test Plan (ROM model with ROM_LATENCY=1, file "12-34,5\n", length 8):
- Reset then idle -> gnt0=gnt1=0, rom_addr=0, busy=0, contention_count=0, no rsp_valid for 10 cycles.
- req0 alone, addr0=0..3 on consecutive cycles -> gnt0 each cycle; rsp0_valid 1 cycle later with data '1','2','-','3' and eof=0; rsp1_valid stays 0.
- req0 and req1 both held for 4 cycles (addr0=0, addr1=4, each advancing on grant) -> grants 0,1,0,1. Responses: rsp0 '1'; rsp1 '4'; rsp0 '2'; rsp1 ','. contention_count=4.
- req1 addr1=9 (past EOF) -> rsp1_valid=1 with rsp1_eof=1 one cycle after the grant.
- Grant to req0 at addr 2, then rst asserted on the next cycle -> no rsp0_valid in any later cycle; busy=0 and prio=0 after reset.
- Rerun with ROM_LATENCY=3 and alternating contention -> every response arrives exactly 3 cycles after its grant with the correct owner; busy stays high until the last response.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared types for the ROM port arbiter: ROM byte width and the requester identifier.
package rom_port_arbiter_pkg;

    localparam int unsigned ROM_DATA_W = 8;

    typedef logic [ROM_DATA_W-1:0] rom_byte_t;
    typedef logic                  req_id_t;

    localparam req_id_t REQ_0 = 1'b0;
    localparam req_id_t REQ_1 = 1'b1;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle of the two requester ports, the ROM port and the status outputs of the arbiter.
interface rom_port_arbiter_if
    import rom_port_arbiter_pkg::*;
#(
    parameter int N_ADDR_BITS = 16,
    parameter int CNT_WIDTH   = 32
);
    logic                 req0;
    logic [N_ADDR_BITS:0] addr0;
    logic                 gnt0;
    logic                 rsp0_valid;
    rom_byte_t            rsp0_data;
    logic                 rsp0_eof;

    logic                 req1;
    logic [N_ADDR_BITS:0] addr1;
    logic                 gnt1;
    logic                 rsp1_valid;
    rom_byte_t            rsp1_data;
    logic                 rsp1_eof;

    logic [N_ADDR_BITS:0] rom_addr;
    rom_byte_t            rom_data;
    logic                 rom_valid;

    logic                 busy;
    logic [CNT_WIDTH-1:0] contention_count;

    // Requesters plus the ROM itself: drive requests and ROM data, observe everything else.
    modport master (
        output req0, addr0, req1, addr1, rom_data, rom_valid,
        input  gnt0, rsp0_valid, rsp0_data, rsp0_eof,
        input  gnt1, rsp1_valid, rsp1_data, rsp1_eof,
        input  rom_addr, busy, contention_count
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_data, rom_valid,
        output gnt0, rsp0_valid, rsp0_data, rsp0_eof,
        output gnt1, rsp1_valid, rsp1_data, rsp1_eof,
        output rom_addr, busy, contention_count
    );

endinterface

// File: rtl/rom_port_arbiter_tag_pipe.sv
// LATENCY-deep shift register of {valid, id} tags that tracks reads in flight through the ROM.
module rom_port_arbiter_tag_pipe
    import rom_port_arbiter_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id,
    output logic    any_valid
);

    logic [LATENCY-1:0] valid_r;
    logic [LATENCY-1:0] id_r;

    // Shift tags one stage per cycle; clear drops every read still in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_r <= '0;
            id_r    <= '0;
        end else begin
            valid_r[0] <= in_valid;
            id_r[0]    <= in_id;
            for (int i = 1; i < LATENCY; i++) begin
                valid_r[i] <= valid_r[i-1];
                id_r[i]    <= id_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[LATENCY-1];
    assign out_id    = id_r[LATENCY-1];
    assign any_valid = |valid_r;

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of one byte-wide ROM read port between two requesters,
// with tagged routing of each returned byte back to the requester that issued it.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int N_ADDR_BITS = 16,
    parameter int ROM_LATENCY = 1,
    parameter int CNT_WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    rom_port_arbiter_if.slave  bus
);

    logic                 prio_r;
    logic [N_ADDR_BITS:0] last_addr_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic                 grant_any_s;
    req_id_t              winner_s;
    logic [N_ADDR_BITS:0] rom_addr_s;
    logic                 tail_valid_s;
    req_id_t              tail_id_s;
    logic                 busy_s;

    // Pick the winner of this cycle; contention is settled by the rotating priority.
    always_comb begin
        grant_any_s = 1'b0;
        winner_s    = REQ_0;
        if (rst) begin
            grant_any_s = 1'b0;
            winner_s    = REQ_0;
        end else if (bus.req0 && bus.req1) begin
            grant_any_s = 1'b1;
            winner_s    = prio_r;
        end else if (bus.req0) begin
            grant_any_s = 1'b1;
            winner_s    = REQ_0;
        end else if (bus.req1) begin
            grant_any_s = 1'b1;
            winner_s    = REQ_1;
        end else begin
            grant_any_s = 1'b0;
            winner_s    = REQ_0;
        end
    end

    // Winner's address goes straight to the ROM; idle cycles replay the last granted one.
    always_comb begin
        rom_addr_s = last_addr_r;
        if (grant_any_s) begin
            rom_addr_s = (winner_s == REQ_1) ? bus.addr1 : bus.addr0;
        end else begin
            rom_addr_s = last_addr_r;
        end
    end

    assign bus.gnt0     = grant_any_s && (winner_s == REQ_0);
    assign bus.gnt1     = grant_any_s && (winner_s == REQ_1);
    assign bus.rom_addr = rom_addr_s;

    // Priority rotation, last address and saturating contention counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r      <= 1'b0;
            last_addr_r <= '0;
            cnt_r       <= '0;
        end else begin
            if (grant_any_s) begin
                prio_r      <= ~winner_s;
                last_addr_r <= rom_addr_s;
            end
            if (bus.req0 && bus.req1 && (cnt_r != {CNT_WIDTH{1'b1}})) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    rom_port_arbiter_tag_pipe #(
        .LATENCY (ROM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .clr       (rst),
        .in_valid  (grant_any_s),
        .in_id     (winner_s),
        .out_valid (tail_valid_s),
        .out_id    (tail_id_s),
        .any_valid (busy_s)
    );

    // Route the ROM byte to the owner of the tag leaving the pipe; idle outputs stay at zero.
    always_comb begin
        bus.rsp0_valid = 1'b0;
        bus.rsp0_data  = '0;
        bus.rsp0_eof   = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp1_data  = '0;
        bus.rsp1_eof   = 1'b0;
        if (tail_valid_s && !rst) begin
            if (tail_id_s == REQ_1) begin
                bus.rsp1_valid = 1'b1;
                bus.rsp1_data  = bus.rom_data;
                bus.rsp1_eof   = ~bus.rom_valid;
            end else begin
                bus.rsp0_valid = 1'b1;
                bus.rsp0_data  = bus.rom_data;
                bus.rsp0_eof   = ~bus.rom_valid;
            end
        end else begin
            bus.rsp0_valid = 1'b0;
            bus.rsp1_valid = 1'b0;
        end
    end

    assign bus.busy             = busy_s;
    assign bus.contention_count = cnt_r;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: two arbiter instances (ROM latency 1 and 3) reading the file "12-34,5\n".
module tb_rom_port_arbiter;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    rom_port_arbiter_if #(.N_ADDR_BITS(16), .CNT_WIDTH(32)) b1 ();
    rom_port_arbiter_if #(.N_ADDR_BITS(16), .CNT_WIDTH(32)) b3 ();

    rom_port_arbiter #(.N_ADDR_BITS(16), .ROM_LATENCY(1), .CNT_WIDTH(32)) u1 (
        .clk (clk), .rst (rst), .bus (b1)
    );
    rom_port_arbiter #(.N_ADDR_BITS(16), .ROM_LATENCY(3), .CNT_WIDTH(32)) u3 (
        .clk (clk), .rst (rst), .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] file_byte(input logic [16:0] a);
        case (a)
            17'd0:   return 8'h31;
            17'd1:   return 8'h32;
            17'd2:   return 8'h2D;
            17'd3:   return 8'h33;
            17'd4:   return 8'h34;
            17'd5:   return 8'h2C;
            17'd6:   return 8'h35;
            17'd7:   return 8'h0A;
            default: return 8'h00;
        endcase
    endfunction

    // ROM models: address captured at the edge, byte usable LATENCY cycles after the grant cycle
    logic [16:0] a1_q;
    logic [16:0] a3_q [3];
    always @(posedge clk) begin
        a1_q    <= b1.rom_addr;
        a3_q[0] <= b3.rom_addr;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign b1.rom_data  = file_byte(a1_q);
    assign b1.rom_valid = (a1_q < 17'd8);
    assign b3.rom_data  = file_byte(a3_q[2]);
    assign b3.rom_valid = (a3_q[2] < 17'd8);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b1.req0 = 1'b0; b1.req1 = 1'b0;
        b3.req0 = 1'b0; b3.req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_all();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b1.req0 = 1'b1; b1.addr0 = 17'd5;
        b3.req1 = 1'b1; b3.addr1 = 17'd6;
        @(negedge clk);
        n_cmp++;
        if ({b1.gnt0, b1.gnt1} !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt_l1: got %b want 00", {b1.gnt0, b1.gnt1});
        end
        n_cmp++;
        if ({b3.gnt0, b3.gnt1} !== 2'b00) begin
            n_err++; $display("FAIL reset_gnt_l3: got %b want 00", {b3.gnt0, b3.gnt1});
        end
        step();
        step();
        idle_all();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({b1.gnt0, b1.gnt1, b1.rsp0_valid, b1.rsp1_valid, b1.busy} !== 5'b00000) begin
                n_err++; $display("FAIL idle_flags c%0d: got %b want 00000", c,
                                  {b1.gnt0, b1.gnt1, b1.rsp0_valid, b1.rsp1_valid, b1.busy});
            end
            n_cmp++;
            if (b1.rom_addr !== 17'd0) begin
                n_err++; $display("FAIL idle_rom_addr c%0d: got %0h want 0", c, b1.rom_addr);
            end
            n_cmp++;
            if (b1.contention_count !== 32'd0) begin
                n_err++; $display("FAIL idle_count c%0d: got %0d want 0", c, b1.contention_count);
            end
            step();
        end
    endtask

    task automatic test_single();
        logic [7:0] e [4];
        e = '{8'h31, 8'h32, 8'h2D, 8'h33};
        for (int i = 0; i < 4; i++) begin
            b1.req0 = 1'b1; b1.addr0 = 17'(i);
            @(negedge clk);
            n_cmp++;
            if ({b1.gnt0, b1.gnt1} !== 2'b10) begin
                n_err++; $display("FAIL single_gnt i%0d: got %b want 10", i, {b1.gnt0, b1.gnt1});
            end
            n_cmp++;
            if (b1.rom_addr !== 17'(i)) begin
                n_err++; $display("FAIL single_rom_addr i%0d: got %0h want %0h", i, b1.rom_addr, i);
            end
            if (i > 0) begin
                n_cmp++;
                if ({b1.rsp0_valid, b1.rsp0_data, b1.rsp0_eof, b1.rsp1_valid} !== {1'b1, e[i-1], 2'b00}) begin
                    n_err++; $display("FAIL single_rsp i%0d: got v%b d%h e%b v1%b want v1 d%h e0 v1 0", i,
                                      b1.rsp0_valid, b1.rsp0_data, b1.rsp0_eof, b1.rsp1_valid, e[i-1]);
                end
            end
            step();
        end
        b1.req0 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b1.rsp0_valid, b1.rsp0_data, b1.rsp0_eof, b1.rsp1_valid} !== {1'b1, e[3], 2'b00}) begin
            n_err++; $display("FAIL single_rsp_last: got v%b d%h e%b v1%b want v1 d%h e0 v1 0",
                              b1.rsp0_valid, b1.rsp0_data, b1.rsp0_eof, b1.rsp1_valid, e[3]);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({b1.rsp0_valid, b1.busy} !== 2'b00) begin
            n_err++; $display("FAIL single_drain: got %b want 00", {b1.rsp0_valid, b1.busy});
        end
        n_cmp++;
        if (b1.contention_count !== 32'd0) begin
            n_err++; $display("FAIL single_count: got %0d want 0", b1.contention_count);
        end
        step();
    endtask

    task automatic test_contention();
        logic [7:0]  ed [4];
        logic [16:0] a0;
        logic [16:0] a1;
        int w;
        int pw;
        ed = '{8'h31, 8'h34, 8'h32, 8'h2C};
        pulse_reset();
        a0 = 17'd0;
        a1 = 17'd4;
        for (int k = 0; k < 4; k++) begin
            b1.req0 = 1'b1; b1.addr0 = a0;
            b1.req1 = 1'b1; b1.addr1 = a1;
            w = k % 2;
            @(negedge clk);
            n_cmp++;
            if ({b1.gnt0, b1.gnt1} !== ((w == 1) ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL cont_gnt k%0d: got %b want winner %0d", k, {b1.gnt0, b1.gnt1}, w);
            end
            n_cmp++;
            if (b1.rom_addr !== ((w == 1) ? a1 : a0)) begin
                n_err++; $display("FAIL cont_rom_addr k%0d: got %0h want %0h", k, b1.rom_addr,
                                  (w == 1) ? a1 : a0);
            end
            if (k > 0) begin
                pw = (k - 1) % 2;
                n_cmp++;
                if ({b1.rsp0_valid, b1.rsp1_valid, (pw == 1) ? b1.rsp1_data : b1.rsp0_data} !==
                    {(pw == 1) ? 2'b01 : 2'b10, ed[k-1]}) begin
                    n_err++; $display("FAIL cont_rsp k%0d: got v%b%b d0 %h d1 %h want owner %0d d%h", k,
                                      b1.rsp0_valid, b1.rsp1_valid, b1.rsp0_data, b1.rsp1_data, pw, ed[k-1]);
                end
            end
            step();
            if (w == 1) a1 = a1 + 17'd1;
            else        a0 = a0 + 17'd1;
        end
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b1.rsp0_valid, b1.rsp1_valid, b1.rsp1_data} !== {2'b01, ed[3]}) begin
            n_err++; $display("FAIL cont_rsp_last: got v%b%b d%h want v01 d%h",
                              b1.rsp0_valid, b1.rsp1_valid, b1.rsp1_data, ed[3]);
        end
        n_cmp++;
        if (b1.contention_count !== 32'd4) begin
            n_err++; $display("FAIL cont_count: got %0d want 4", b1.contention_count);
        end
        step();
    endtask

    task automatic test_eof();
        logic [16:0] ad [3];
        logic [8:0]  er [3];
        ad = '{17'd7, 17'd8, 17'd9};
        er = '{{8'h0A, 1'b0}, {8'h00, 1'b1}, {8'h00, 1'b1}};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                b1.req1 = 1'b1; b1.addr1 = ad[i];
            end else begin
                b1.req1 = 1'b0;
            end
            @(negedge clk);
            if (i < 3) begin
                n_cmp++;
                if ({b1.gnt0, b1.gnt1, b1.rom_addr} !== {2'b01, ad[i]}) begin
                    n_err++; $display("FAIL eof_gnt i%0d: got g%b a%0h want g01 a%0h", i,
                                      {b1.gnt0, b1.gnt1}, b1.rom_addr, ad[i]);
                end
            end
            if (i > 0) begin
                n_cmp++;
                if ({b1.rsp0_valid, b1.rsp1_valid, b1.rsp1_data, b1.rsp1_eof} !== {2'b01, er[i-1]}) begin
                    n_err++; $display("FAIL eof_rsp i%0d: got v%b%b d%h e%b want v01 d%h e%b", i,
                                      b1.rsp0_valid, b1.rsp1_valid, b1.rsp1_data, b1.rsp1_eof,
                                      er[i-1][8:1], er[i-1][0]);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        b1.req0 = 1'b1; b1.addr0 = 17'd2;
        @(negedge clk);
        n_cmp++;
        if ({b1.gnt0, b1.gnt1} !== 2'b10) begin
            n_err++; $display("FAIL mid_gnt: got %b want 10", {b1.gnt0, b1.gnt1});
        end
        step();
        b1.req0 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({b1.rsp0_valid, b1.rsp1_valid, b1.busy} !== 3'b000) begin
                n_err++; $display("FAIL mid_discard c%0d: got %b want 000", c,
                                  {b1.rsp0_valid, b1.rsp1_valid, b1.busy});
            end
            step();
        end
        b1.req0 = 1'b1; b1.addr0 = 17'd0;
        b1.req1 = 1'b1; b1.addr1 = 17'd1;
        @(negedge clk);
        n_cmp++;
        if ({b1.gnt0, b1.gnt1} !== 2'b10) begin
            n_err++; $display("FAIL mid_prio: got %b want 10", {b1.gnt0, b1.gnt1});
        end
        step();
        b1.req0 = 1'b0;
        b1.req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({b1.rsp0_valid, b1.rsp1_valid, b1.rsp0_data} !== {2'b10, 8'h31}) begin
            n_err++; $display("FAIL mid_rerun: got v%b%b d%h want v10 d31",
                              b1.rsp0_valid, b1.rsp1_valid, b1.rsp0_data);
        end
        step();
        step();
    endtask

    task automatic test_latency3();
        logic [16:0] a0;
        logic [16:0] a1;
        logic [7:0]  ed [6];
        int w;
        int r;
        a0 = 17'd0;
        a1 = 17'd4;
        ed = '{8'h31, 8'h34, 8'h32, 8'h2C, 8'h2D, 8'h35};
        for (int c = 0; c < 11; c++) begin
            if (c < 6) begin
                b3.req0 = 1'b1; b3.addr0 = a0;
                b3.req1 = 1'b1; b3.addr1 = a1;
            end else begin
                b3.req0 = 1'b0;
                b3.req1 = 1'b0;
            end
            w = c % 2;
            @(negedge clk);
            if (c < 6) begin
                n_cmp++;
                if ({b3.gnt0, b3.gnt1} !== ((w == 1) ? 2'b01 : 2'b10)) begin
                    n_err++; $display("FAIL l3_gnt c%0d: got %b want winner %0d", c, {b3.gnt0, b3.gnt1}, w);
                end
            end
            if (c >= 3 && c < 9) begin
                r = (c - 3) % 2;
                n_cmp++;
                if ({b3.rsp0_valid, b3.rsp1_valid, (r == 1) ? b3.rsp1_data : b3.rsp0_data} !==
                    {(r == 1) ? 2'b01 : 2'b10, ed[c-3]}) begin
                    n_err++; $display("FAIL l3_rsp c%0d: got v%b%b d0 %h d1 %h want owner %0d d%h", c,
                                      b3.rsp0_valid, b3.rsp1_valid, b3.rsp0_data, b3.rsp1_data, r, ed[c-3]);
                end
            end else begin
                n_cmp++;
                if ({b3.rsp0_valid, b3.rsp1_valid} !== 2'b00) begin
                    n_err++; $display("FAIL l3_norsp c%0d: got %b want 00", c, {b3.rsp0_valid, b3.rsp1_valid});
                end
            end
            n_cmp++;
            if (b3.busy !== ((c >= 1 && c <= 8) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL l3_busy c%0d: got %b want %b", c, b3.busy, (c >= 1 && c <= 8));
            end
            step();
            if (c < 6) begin
                if (w == 1) a1 = a1 + 17'd1;
                else        a0 = a0 + 17'd1;
            end
        end
        n_cmp++;
        if (b3.contention_count !== 32'd6) begin
            n_err++; $display("FAIL l3_count: got %0d want 6", b3.contention_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        b1.req0 = 1'b0; b1.req1 = 1'b0; b1.addr0 = 17'd0; b1.addr1 = 17'd0;
        b3.req0 = 1'b0; b3.req1 = 1'b0; b3.addr0 = 17'd0; b3.addr1 = 17'd0;
        test_reset();
        test_single();
        test_contention();
        test_eof();
        test_reset_mid();
        test_latency3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
